// File: rtl/modulus_game_ctrl.sv
// Modulus quiz game controller: issues dividend/divisor problems, scores keypad
// answers, and drains health over time at a rate that speeds up with level.
module modulus_game_ctrl #(
    parameter int unsigned DIV_W       = 7,
    parameter int unsigned HEALTH_MAX  = 99,
    parameter int unsigned RATE_INIT   = 36000000,
    parameter int unsigned RATE_STEP   = 3000000,
    parameter int unsigned RATE_MIN    = 6000000,
    parameter int unsigned LEVEL_EVERY = 5,
    parameter int unsigned REWARD      = 3,
    parameter int unsigned PENALTY     = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             check_n,
    input  logic [3:0]       answer,
    input  logic [DIV_W-1:0] rand_dividend,
    input  logic [3:0]       rand_divisor,
    output logic [DIV_W-1:0] dividend,
    output logic [3:0]       divisor,
    output logic [6:0]       health,
    output logic [3:0]       level,
    output logic [9:0]       score,
    output logic [1:0]       state,
    output logic             game_over,
    output logic             correct_pulse,
    output logic             wrong_pulse
);

    localparam int unsigned RATE_W   = $clog2(RATE_INIT + 1);
    localparam int unsigned CMP_W    = (DIV_W > 4) ? DIV_W : 4;
    localparam int unsigned STREAK_W = $clog2(LEVEL_EVERY + 1);
    localparam logic signed [9:0] HMAX_S    = 10'(HEALTH_MAX);
    localparam logic signed [9:0] REWARD_S  = 10'(REWARD);
    localparam logic signed [9:0] PENALTY_S = 10'(PENALTY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        WAIT = 2'd2,
        OVER = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                btn_q, btn_d;
    logic [DIV_W-1:0]    dividend_q, dividend_d;
    logic [3:0]          divisor_q, divisor_d;
    logic [6:0]          health_q, health_d;
    logic [3:0]          level_q, level_d;
    logic [9:0]          score_q, score_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [RATE_W-1:0]   rate_q, rate_d;
    logic [RATE_W-1:0]   cnt_q, cnt_d;
    logic                correct_q, correct_d;
    logic                wrong_q, wrong_d;

    logic                press_c;
    logic                answer_ok_c;
    logic                tick_c;
    logic [CMP_W-1:0]    rem_c;
    logic signed [9:0]   h_net_c;

    always_comb begin
        state_d    = state_q;
        btn_d      = check_n;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        health_d   = health_q;
        level_d    = level_q;
        score_d    = score_q;
        streak_d   = streak_q;
        rate_d     = rate_q;
        cnt_d      = cnt_q;
        correct_d  = 1'b0;
        wrong_d    = 1'b0;

        press_c     = btn_q & ~check_n;
        rem_c       = CMP_W'(dividend_q) % CMP_W'(divisor_q);
        answer_ok_c = (CMP_W'(answer) == rem_c);
        tick_c      = (cnt_q == rate_q - RATE_W'(1));
        h_net_c     = $signed({3'b000, health_q});

        case (state_q)
            IDLE: begin
                if (press_c) state_d = GEN;
            end
            GEN: begin
                dividend_d = rand_dividend;
                divisor_d  = (rand_divisor >= 4'd2 && rand_divisor <= 4'd9)
                           ? rand_divisor : {1'b0, rand_divisor[2:0]} + 4'd2;
                cnt_d      = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                cnt_d = tick_c ? '0 : cnt_q + RATE_W'(1);
                if (tick_c) h_net_c = h_net_c - 10'sd1;
                if (press_c && answer_ok_c) begin
                    h_net_c   = h_net_c + REWARD_S;
                    correct_d = 1'b1;
                    score_d   = (score_q == 10'd999) ? score_q : score_q + 10'd1;
                    if (streak_q == STREAK_W'(LEVEL_EVERY - 1)) begin
                        streak_d = '0;
                        level_d  = (level_q == 4'd15) ? level_q : level_q + 4'd1;
                        rate_d   = (32'(rate_q) >= RATE_MIN + RATE_STEP)
                                 ? rate_q - RATE_W'(RATE_STEP) : RATE_W'(RATE_MIN);
                    end else begin
                        streak_d = streak_q + STREAK_W'(1);
                    end
                end else if (press_c) begin
                    h_net_c  = h_net_c - PENALTY_S;
                    wrong_d  = 1'b1;
                    streak_d = '0;
                end
                // Saturation is applied once to the combined decay/reward/penalty
                if (h_net_c < 10'sd0)       health_d = 7'd0;
                else if (h_net_c > HMAX_S)  health_d = 7'(HEALTH_MAX);
                else                        health_d = 7'(h_net_c);
                if (health_d == 7'd0) begin
                    state_d = OVER;
                end else if (press_c && answer_ok_c) begin
                    state_d = GEN;
                    cnt_d   = '0;
                end
            end
            OVER: begin
                if (press_c) begin
                    state_d  = GEN;
                    health_d = 7'(HEALTH_MAX);
                    score_d  = '0;
                    level_d  = '0;
                    streak_d = '0;
                    rate_d   = RATE_W'(RATE_INIT);
                    cnt_d    = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            btn_q      <= 1'b1;
            dividend_q <= '0;
            divisor_q  <= 4'd2;
            health_q   <= 7'(HEALTH_MAX);
            level_q    <= '0;
            score_q    <= '0;
            streak_q   <= '0;
            rate_q     <= RATE_W'(RATE_INIT);
            cnt_q      <= '0;
            correct_q  <= 1'b0;
            wrong_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            btn_q      <= btn_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            health_q   <= health_d;
            level_q    <= level_d;
            score_q    <= score_d;
            streak_q   <= streak_d;
            rate_q     <= rate_d;
            cnt_q      <= cnt_d;
            correct_q  <= correct_d;
            wrong_q    <= wrong_d;
        end
    end

    assign dividend      = dividend_q;
    assign divisor       = divisor_q;
    assign health        = health_q;
    assign level         = level_q;
    assign score         = score_q;
    assign state         = state_q;
    assign game_over     = (state_q == OVER);
    assign correct_pulse = correct_q;
    assign wrong_pulse   = wrong_q;

endmodule

// File: tb/tb_modulus_game_ctrl.sv
// Bench for modulus_game_ctrl: directed scenarios plus random play, every cycle
// checked against a rule-level game model.
module tb_modulus_game_ctrl;

    localparam int unsigned DIV_W = 7;
    localparam int HM = 10;
    localparam int RI = 20;
    localparam int RS = 5;
    localparam int RM = 8;
    localparam int LE = 2;
    localparam int RW = 3;
    localparam int PN = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             check_n = 1'b1;
    logic [3:0]       answer = 4'd0;
    logic [DIV_W-1:0] rand_dividend = '0;
    logic [3:0]       rand_divisor = 4'd0;
    logic [DIV_W-1:0] dividend;
    logic [3:0]       divisor;
    logic [6:0]       health;
    logic [3:0]       level;
    logic [9:0]       score;
    logic [1:0]       state;
    logic             game_over;
    logic             correct_pulse;
    logic             wrong_pulse;

    int total = 0;
    int bad   = 0;

    // Rule-level game model: m_n counts WAIT cycles since the problem was issued
    int m_st, m_h, m_sc, m_lv, m_sk, m_per, m_n, m_dd, m_dv, m_cp, m_wp;
    logic m_prev;

    modulus_game_ctrl #(
        .DIV_W(DIV_W), .HEALTH_MAX(HM), .RATE_INIT(RI), .RATE_STEP(RS),
        .RATE_MIN(RM), .LEVEL_EVERY(LE), .REWARD(RW), .PENALTY(PN)
    ) dut (
        .clk(clk), .reset(reset), .check_n(check_n), .answer(answer),
        .rand_dividend(rand_dividend), .rand_divisor(rand_divisor),
        .dividend(dividend), .divisor(divisor), .health(health), .level(level),
        .score(score), .state(state), .game_over(game_over),
        .correct_pulse(correct_pulse), .wrong_pulse(wrong_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic btn, input logic rst);
        bit press, ok;
        int hn;
        if (rst) begin
            m_st = 0; m_h = HM; m_sc = 0; m_lv = 0; m_sk = 0; m_per = RI;
            m_n = 0; m_dd = 0; m_dv = 2; m_cp = 0; m_wp = 0; m_prev = 1'b1;
            return;
        end
        press  = m_prev && !btn;
        m_prev = btn;
        m_cp = 0;
        m_wp = 0;
        case (m_st)
            0: if (press) m_st = 1;
            1: begin
                m_dd = int'(rand_dividend);
                m_dv = (rand_divisor >= 2 && rand_divisor <= 9) ? int'(rand_divisor)
                                                                : int'(rand_divisor) % 8 + 2;
                m_n  = 0;
                m_st = 2;
            end
            2: begin
                m_n++;
                hn = m_h - (((m_n % m_per) == 0) ? 1 : 0);
                ok = press && (int'(answer) == m_dd % m_dv);
                if (ok) begin
                    hn  += RW;
                    m_cp = 1;
                    m_sc = (m_sc < 999) ? m_sc + 1 : 999;
                    m_sk++;
                    if (m_sk == LE) begin
                        m_sk  = 0;
                        m_lv  = (m_lv < 15) ? m_lv + 1 : 15;
                        m_per = (m_per - RS > RM) ? m_per - RS : RM;
                    end
                end else if (press) begin
                    hn  -= PN;
                    m_wp = 1;
                    m_sk = 0;
                end
                m_h = (hn < 0) ? 0 : (hn > HM) ? HM : hn;
                if (m_h == 0) m_st = 3;
                else if (ok)  m_st = 1;
            end
            default: if (press) begin
                m_st = 1; m_h = HM; m_sc = 0; m_lv = 0; m_sk = 0; m_per = RI;
            end
        endcase
    endtask

    task automatic cyc(input logic btn, input logic rst);
        check_n = btn;
        reset   = rst;
        @(posedge clk);
        model_edge(btn, rst);
        #1;
        chk("state",    32'(state),         32'(m_st));
        chk("health",   32'(health),        32'(m_h));
        chk("score",    32'(score),         32'(m_sc));
        chk("level",    32'(level),         32'(m_lv));
        chk("dividend", 32'(dividend),      32'(m_dd));
        chk("divisor",  32'(divisor),       32'(m_dv));
        chk("correct",  32'(correct_pulse), 32'(m_cp));
        chk("wrong",    32'(wrong_pulse),   32'(m_wp));
        chk("gameover", 32'(game_over),     32'(m_st == 3));
    endtask

    task automatic randomize_problem();
        rand_dividend = DIV_W'($urandom_range(0, 127));
        rand_divisor  = 4'($urandom_range(0, 15));
    endtask

    task automatic correct_press();
        answer = 4'(m_dd % m_dv);
        randomize_problem();
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
    endtask

    task automatic measure_period(input string tag, input int exp);
        logic [6:0] h0;
        int n;
        h0 = health;
        n  = 0;
        do begin
            cyc(1'b1, 1'b0);
            n++;
        end while (health == h0 && n < 60);
        chk(tag, 32'(n), 32'(exp));
    endtask

    initial begin
        int n;
        int pulses;

        // Reset
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_health", 32'(health), 32'd10);
        chk("rst_divisor", 32'(divisor), 32'd2);
        chk("rst_dividend", 32'(dividend), 32'd0);

        // First problem 17 mod 5, answered correctly
        rand_dividend = 7'd17;
        rand_divisor  = 4'd5;
        answer        = 4'd2;
        cyc(1'b0, 1'b0);
        chk("idle_press", 32'(state), 32'd1);
        cyc(1'b1, 1'b0);
        chk("gen_dividend", 32'(dividend), 32'd17);
        chk("gen_divisor", 32'(divisor), 32'd5);
        cyc(1'b0, 1'b0);
        chk("first_correct", 32'(correct_pulse), 32'd1);
        chk("first_health", 32'(health), 32'd10);
        chk("first_score", 32'(score), 32'd1);
        rand_dividend = DIV_W'($urandom_range(0, 127));
        rand_divisor  = 4'd0;
        cyc(1'b1, 1'b0);
        chk("div_from_0", 32'(divisor), 32'd2);

        // Second correct: level-up, decay period 15
        answer = 4'(m_dd % m_dv);
        cyc(1'b0, 1'b0);
        chk("level1", 32'(level), 32'd1);
        rand_divisor = 4'd12;
        cyc(1'b1, 1'b0);
        chk("div_from_12", 32'(divisor), 32'd6);
        measure_period("period_l1", 15);

        // Two wrong answers from full health
        correct_press();
        chk("topped_up", 32'(health), 32'd10);
        answer = 4'((m_dd % m_dv + 1) % m_dv);
        cyc(1'b0, 1'b0);
        chk("wrong1_health", 32'(health), 32'd5);
        chk("wrong1_pulse", 32'(wrong_pulse), 32'd1);
        chk("wrong1_state", 32'(state), 32'd2);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        chk("wrong2_health", 32'(health), 32'd0);
        chk("wrong2_over", 32'(state), 32'd3);
        repeat (5) cyc(1'b1, 1'b0);
        chk("frozen_score", 32'(score), 32'd3);
        chk("frozen_level", 32'(level), 32'd1);

        // Restart, then idle decay all the way to OVER
        cyc(1'b0, 1'b0);
        chk("restart_state", 32'(state), 32'd1);
        chk("restart_health", 32'(health), 32'd10);
        chk("restart_score", 32'(score), 32'd0);
        chk("restart_level", 32'(level), 32'd0);
        cyc(1'b1, 1'b0);
        n = 0;
        while (state == 2'd2 && n < 300) begin
            cyc(1'b1, 1'b0);
            n++;
        end
        chk("decay_cycles", 32'(n), 32'd200);
        chk("decay_over", 32'(state), 32'd3);
        cyc(1'b0, 1'b0);
        chk("over_press_health", 32'(health), 32'd10);
        chk("over_press_score", 32'(score), 32'd0);
        cyc(1'b1, 1'b0);

        // Four level-ups: period 15, 10, 8, 8
        repeat (8) correct_press();
        chk("level4", 32'(level), 32'd4);
        measure_period("period_floor", 8);

        // Button held low counts as a single press
        answer = 4'((m_dd % m_dv + 1) % m_dv);
        pulses = 0;
        repeat (50) begin
            cyc(1'b0, 1'b0);
            pulses += int'(wrong_pulse);
        end
        chk("held_once", 32'(pulses), 32'd1);
        cyc(1'b1, 1'b0);

        // Reset in the middle of WAIT
        randomize_problem();
        if (m_st != 2) begin
            cyc(1'b0, 1'b0);
            cyc(1'b1, 1'b0);
        end
        repeat (3) cyc(1'b1, 1'b0);
        chk("pre_reset_wait", 32'(state), 32'd2);
        cyc(1'b1, 1'b1);
        chk("reset_mid_wait", 32'(state), 32'd0);
        chk("reset_mid_health", 32'(health), 32'd10);

        // Random play
        for (int i = 0; i < 40; i++) begin
            randomize_problem();
            if ($urandom_range(0, 1) == 1) answer = 4'(m_dd % m_dv);
            else                           answer = 4'($urandom_range(0, 15));
            cyc(1'b0, 1'b0);
            repeat ($urandom_range(1, 3)) cyc(1'b1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
